// File: rtl/fpu_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_mul_arbiter
//  Description : Round-robin front end that shares one single-precision FP
//                multiplier core among NREQ requesters. Operands are
//                registered into the core, the result and flags are captured
//                MUL_LAT cycles later and held as a response tagged with the
//                requester id until it is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_mul_arbiter #(
    parameter int NREQ    = 2,
    parameter int ID_W    = 1,
    parameter int MUL_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*2-1:0]    req_rmode,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    output logic [1:0]           mul_rmode,
    input  logic [31:0]          mul_result,
    input  logic                 mul_error,
    input  logic                 mul_overflow,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_result,
    output logic                 rsp_error,
    output logic                 rsp_overflow,
    output logic                 busy
);

    localparam int              c_CNT_W     = 3;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(MUL_LAT - 1);
    localparam logic [ID_W:0]   c_NREQ      = (ID_W + 1)'(NREQ);
    localparam logic [ID_W-1:0] c_LAST_INIT = ID_W'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ID_W-1:0]     r_last_grant;
    logic [ID_W-1:0]     r_id;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [31:0]         r_mul_a;
    logic [31:0]         r_mul_b;
    logic [1:0]          r_mul_rmode;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_result;
    logic                r_rsp_error;
    logic                r_rsp_overflow;

    logic [ID_W:0]       w_idx;
    logic [ID_W-1:0]     w_grant;
    logic                w_grant_vld;
    logic                w_accept;
    logic                w_wait_done;
    logic                w_rsp_done;

    // Round-robin search: walk downward so the nearest requester after
    // last_grant is the final (winning) assignment.
    always_comb begin
        w_idx       = '0;
        w_grant     = '0;
        w_grant_vld = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = {1'b0, r_last_grant} + (ID_W + 1)'(k);
            if (w_idx >= c_NREQ) begin
                w_idx = w_idx - c_NREQ;
            end
            if (req_valid[w_idx[ID_W-1:0]]) begin
                w_grant     = w_idx[ID_W-1:0];
                w_grant_vld = 1'b1;
            end
        end
    end

    assign w_accept    = (r_state == S_IDLE) && w_grant_vld;
    assign w_wait_done = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_rsp_done  = (r_state == S_RESP) && rsp_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and ready decode; ready is masked while reset is asserted
    // so every output reads zero during reset.
    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_WAIT;
                    if (!reset) begin
                        req_ready[w_grant] = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (w_wait_done) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (w_rsp_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand capture on accept, latency countdown, response capture/release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant   <= c_LAST_INIT;
            r_id           <= '0;
            r_cnt          <= '0;
            r_mul_a        <= '0;
            r_mul_b        <= '0;
            r_mul_rmode    <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_error    <= 1'b0;
            r_rsp_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mul_a      <= req_a[{w_grant, 5'b00000} +: 32];
                r_mul_b      <= req_b[{w_grant, 5'b00000} +: 32];
                r_mul_rmode  <= req_rmode[{w_grant, 1'b0} +: 2];
                r_id         <= w_grant;
                r_last_grant <= w_grant;
                r_cnt        <= c_CNT_INIT;
            end
            if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_wait_done) begin
                r_rsp_result   <= mul_result;
                r_rsp_error    <= mul_error;
                r_rsp_overflow <= mul_overflow;
                r_rsp_valid    <= 1'b1;
            end
            if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign mul_a        = r_mul_a;
    assign mul_b        = r_mul_b;
    assign mul_rmode    = r_mul_rmode;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_id;
    assign rsp_result   = r_rsp_result;
    assign rsp_error    = r_rsp_error;
    assign rsp_overflow = r_rsp_overflow;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fpu_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_mul_arbiter
//  Description : Directed self-checking bench for fpu_mul_arbiter. Instance a
//                is NREQ=2/MUL_LAT=1, instance b is NREQ=3/MUL_LAT=3. A small
//                behavioural core model answers the known operand pairs and
//                returns A^B otherwise so operand routing is visible.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_mul_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    // instance a signals
    logic [1:0]  a_req_valid, a_req_ready;
    logic [63:0] a_req_a, a_req_b;
    logic [3:0]  a_req_rmode;
    logic [31:0] a_mul_a, a_mul_b, a_mul_result, a_rsp_result;
    logic [1:0]  a_mul_rmode;
    logic        a_mul_error, a_mul_overflow, a_rsp_valid, a_rsp_ready;
    logic [0:0]  a_rsp_id;
    logic        a_rsp_error, a_rsp_overflow, a_busy;

    // instance b signals
    logic [2:0]  b_req_valid, b_req_ready;
    logic [95:0] b_req_a, b_req_b;
    logic [5:0]  b_req_rmode;
    logic [31:0] b_mul_a, b_mul_b, b_mul_result, b_rsp_result;
    logic [1:0]  b_mul_rmode;
    logic        b_mul_error, b_mul_overflow, b_rsp_valid, b_rsp_ready;
    logic [1:0]  b_rsp_id;
    logic        b_rsp_error, b_rsp_overflow, b_busy;

    // Core model: {result, error, overflow}
    function automatic logic [33:0] core_fn(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3FC0_0000 && b == 32'h4000_0000) return {32'h4040_0000, 2'b00};
        if (a == 32'h7FC0_0000 || b == 32'h7FC0_0000) return {32'h7FC0_0000, 2'b10};
        if (a == 32'h7F80_0000 && b == 32'h7F80_0000) return {32'h7F80_0000, 2'b01};
        return {a ^ b, 2'b00};
    endfunction

    assign {a_mul_result, a_mul_error, a_mul_overflow} = core_fn(a_mul_a, a_mul_b);
    assign {b_mul_result, b_mul_error, b_mul_overflow} = core_fn(b_mul_a, b_mul_b);

    fpu_mul_arbiter #(.NREQ(2), .ID_W(1), .MUL_LAT(1)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_a(a_req_a), .req_b(a_req_b), .req_rmode(a_req_rmode),
        .mul_a(a_mul_a), .mul_b(a_mul_b), .mul_rmode(a_mul_rmode),
        .mul_result(a_mul_result), .mul_error(a_mul_error), .mul_overflow(a_mul_overflow),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_id(a_rsp_id),
        .rsp_result(a_rsp_result), .rsp_error(a_rsp_error), .rsp_overflow(a_rsp_overflow),
        .busy(a_busy)
    );

    fpu_mul_arbiter #(.NREQ(3), .ID_W(2), .MUL_LAT(3)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_a(b_req_a), .req_b(b_req_b), .req_rmode(b_req_rmode),
        .mul_a(b_mul_a), .mul_b(b_mul_b), .mul_rmode(b_mul_rmode),
        .mul_result(b_mul_result), .mul_error(b_mul_error), .mul_overflow(b_mul_overflow),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
        .rsp_result(b_rsp_result), .rsp_error(b_rsp_error), .rsp_overflow(b_rsp_overflow),
        .busy(b_busy)
    );

    task automatic test_reset();
        logic [104:0] obs_a;
        logic [106:0] obs_b;
        reset = 1'b1;
        a_req_valid = '0; a_req_a = '0; a_req_b = '0; a_req_rmode = '0; a_rsp_ready = 1'b0;
        b_req_valid = '0; b_req_a = '0; b_req_b = '0; b_req_rmode = '0; b_rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        obs_a = {a_req_ready, a_mul_a, a_mul_b, a_mul_rmode, a_rsp_valid, a_rsp_id,
                 a_rsp_result, a_rsp_error, a_rsp_overflow, a_busy};
        n_checks++;
        if (obs_a !== '0) $display("FAIL reset_a: got %h want 0", obs_a);
        else n_pass++;
        obs_b = {b_req_ready, b_mul_a, b_mul_b, b_mul_rmode, b_rsp_valid, b_rsp_id,
                 b_rsp_result, b_rsp_error, b_rsp_overflow, b_busy};
        n_checks++;
        if (obs_b !== '0) $display("FAIL reset_b: got %h want 0", obs_b);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        a_req_a[31:0] = 32'h3FC0_0000;
        a_req_b[31:0] = 32'h4000_0000;
        a_req_rmode[1:0] = 2'b10;
        a_req_valid = 2'b01;
        a_rsp_ready = 1'b0;
        #1;
        n_checks++;
        if (a_req_ready !== 2'b01) $display("FAIL basic_ready: got %b want 01", a_req_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({a_mul_a, a_mul_b, a_mul_rmode, a_busy, a_rsp_valid, a_req_ready} !==
            {32'h3FC0_0000, 32'h4000_0000, 2'b10, 1'b1, 1'b0, 2'b00})
            $display("FAIL basic_issue: got %h %h %b busy=%b rv=%b rdy=%b want 3fc00000 40000000 10 1 0 00",
                     a_mul_a, a_mul_b, a_mul_rmode, a_busy, a_rsp_valid, a_req_ready);
        else n_pass++;
        a_req_valid = 2'b00;
        @(negedge clk);
        n_checks++;
        if ({a_rsp_valid, a_rsp_id, a_rsp_result, a_rsp_error, a_rsp_overflow} !==
            {1'b1, 1'b0, 32'h4040_0000, 1'b0, 1'b0})
            $display("FAIL basic_rsp: got v=%b id=%0d res=%h e=%b o=%b want 1 0 40400000 0 0",
                     a_rsp_valid, a_rsp_id, a_rsp_result, a_rsp_error, a_rsp_overflow);
        else n_pass++;
        a_rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({a_rsp_valid, a_busy} !== 2'b00)
            $display("FAIL basic_release: got v=%b busy=%b want 0 0", a_rsp_valid, a_busy);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_res [2];
        int cyc;
        exp_res[0] = 32'h1111_000F;
        exp_res[1] = 32'h2222_00AA;
        a_req_a = {32'h2222_0000, 32'h1111_0000};
        a_req_b = {32'h0000_00AA, 32'h0000_000F};
        a_req_rmode = 4'b0110;
        a_rsp_ready = 1'b1;
        reset = 1'b1;
        a_req_valid = 2'b11;
        @(negedge clk);
        reset = 1'b0;
        for (int t = 0; t < 4; t++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!a_rsp_valid && cyc < 20);
            n_checks++;
            if (a_rsp_id !== 1'(t % 2) || a_rsp_result !== exp_res[t % 2] || a_rsp_valid !== 1'b1)
                $display("FAIL rr_rsp%0d: got v=%b id=%0d res=%h want 1 %0d %h",
                         t, a_rsp_valid, a_rsp_id, a_rsp_result, t % 2, exp_res[t % 2]);
            else n_pass++;
            if (t > 0) begin
                n_checks++;
                if (cyc !== 3) $display("FAIL rr_interval%0d: got %0d want 3", t, cyc);
                else n_pass++;
            end
        end
        a_req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int cyc;
        a_rsp_ready = 1'b0;
        a_req_valid = 2'b11;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!a_rsp_valid && cyc < 20);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({a_rsp_valid, a_rsp_id, a_rsp_result, a_req_ready, a_busy, a_mul_a} !==
                {1'b1, 1'b0, 32'h1111_000F, 2'b00, 1'b1, 32'h1111_0000})
                $display("FAIL bp_hold%0d: got v=%b id=%0d res=%h rdy=%b busy=%b ma=%h want 1 0 1111000f 00 1 11110000",
                         i, a_rsp_valid, a_rsp_id, a_rsp_result, a_req_ready, a_busy, a_mul_a);
            else n_pass++;
            @(negedge clk);
        end
        a_rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({a_req_ready, a_rsp_valid, a_busy} !== {2'b10, 1'b0, 1'b0})
            $display("FAIL bp_regrant: got rdy=%b v=%b busy=%b want 10 0 0", a_req_ready, a_rsp_valid, a_busy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({a_busy, a_mul_a} !== {1'b1, 32'h2222_0000})
            $display("FAIL bp_issue: got busy=%b ma=%h want 1 22220000", a_busy, a_mul_a);
        else n_pass++;
        a_req_valid = 2'b00;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (a_busy && cyc < 20);
    endtask

    task automatic test_flags();
        logic [31:0] va [2];
        logic [31:0] vb [2];
        logic [1:0]  vrm [2];
        logic [33:0] vexp [2];
        int cyc;
        va[0] = 32'h7FC0_0000; vb[0] = 32'h3F80_0000; vrm[0] = 2'b01; vexp[0] = {32'h7FC0_0000, 2'b10};
        va[1] = 32'h7F80_0000; vb[1] = 32'h7F80_0000; vrm[1] = 2'b11; vexp[1] = {32'h7F80_0000, 2'b01};
        a_rsp_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            a_req_a[32*r +: 32] = va[r];
            a_req_b[32*r +: 32] = vb[r];
            a_req_rmode[2*r +: 2] = vrm[r];
            a_req_valid = 2'(1 << r);
            #1;
            n_checks++;
            if (a_req_ready !== 2'(1 << r)) $display("FAIL flags_ready%0d: got %b want %b", r, a_req_ready, 2'(1 << r));
            else n_pass++;
            @(negedge clk);
            a_req_valid = 2'b00;
            n_checks++;
            if ({a_mul_a, a_mul_b, a_mul_rmode} !== {va[r], vb[r], vrm[r]})
                $display("FAIL flags_ops%0d: got %h %h %b want %h %h %b", r, a_mul_a, a_mul_b, a_mul_rmode, va[r], vb[r], vrm[r]);
            else n_pass++;
            cyc = 0;
            while (!a_rsp_valid && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            n_checks++;
            if ({a_rsp_valid, a_rsp_id, a_rsp_result, a_rsp_error, a_rsp_overflow} !== {1'b1, 1'(r), vexp[r]})
                $display("FAIL flags_rsp%0d: got v=%b id=%0d res=%h e=%b o=%b want 1 %0d %h",
                         r, a_rsp_valid, a_rsp_id, a_rsp_result, a_rsp_error, a_rsp_overflow, r, vexp[r]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [104:0] obs_a;
        int cyc;
        a_rsp_ready = 1'b1;
        a_req_valid = 2'b01;
        @(negedge clk);
        a_req_valid = 2'b11;
        n_checks++;
        if ({a_busy, a_rsp_valid} !== 2'b10) $display("FAIL rmid_wait: got busy=%b v=%b want 1 0", a_busy, a_rsp_valid);
        else n_pass++;
        reset = 1'b1;
        #1;
        obs_a = {a_req_ready, a_mul_a, a_mul_b, a_mul_rmode, a_rsp_valid, a_rsp_id,
                 a_rsp_result, a_rsp_error, a_rsp_overflow, a_busy};
        n_checks++;
        if (obs_a !== '0) $display("FAIL rmid_zero: got %h want 0", obs_a);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (a_rsp_valid !== 1'b0) $display("FAIL rmid_norsp: got %b want 0", a_rsp_valid);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if (a_req_ready !== 2'b01) $display("FAIL rmid_first: got %b want 01", a_req_ready);
        else n_pass++;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!a_rsp_valid && cyc < 20);
        n_checks++;
        if ({a_rsp_valid, a_rsp_id} !== 2'b10) $display("FAIL rmid_rsp: got v=%b id=%0d want 1 0", a_rsp_valid, a_rsp_id);
        else n_pass++;
        a_req_valid = 2'b00;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (a_busy && cyc < 20);
    endtask

    task automatic test_latency3();
        logic [31:0] ea [3];
        logic [31:0] eb [3];
        logic [31:0] er [3];
        int id;
        ea[0] = 32'h0101_0101; eb[0] = 32'h1000_0000; er[0] = 32'h1101_0101;
        ea[1] = 32'h0202_0202; eb[1] = 32'h2000_0000; er[1] = 32'h2202_0202;
        ea[2] = 32'h0303_0303; eb[2] = 32'h3000_0000; er[2] = 32'h3303_0303;
        b_req_a = {ea[2], ea[1], ea[0]};
        b_req_b = {eb[2], eb[1], eb[0]};
        b_rsp_ready = 1'b1;
        b_req_valid = 3'b111;
        for (int t = 0; t < 4; t++) begin
            id = t % 3;
            #1;
            n_checks++;
            if (b_req_ready !== 3'(1 << id)) $display("FAIL lat_grant%0d: got %b want %b", t, b_req_ready, 3'(1 << id));
            else n_pass++;
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                n_checks++;
                if ({b_rsp_valid, b_mul_a, b_mul_b} !== {(c == 3), ea[id], eb[id]})
                    $display("FAIL lat_t%0d_c%0d: got v=%b ma=%h mb=%h want %b %h %h",
                             t, c, b_rsp_valid, b_mul_a, b_mul_b, (c == 3), ea[id], eb[id]);
                else n_pass++;
                if (c < 3) @(negedge clk);
            end
            n_checks++;
            if ({b_rsp_id, b_rsp_result} !== {2'(id), er[id]})
                $display("FAIL lat_rsp%0d: got id=%0d res=%h want %0d %h", t, b_rsp_id, b_rsp_result, id, er[id]);
            else n_pass++;
            @(negedge clk);
        end
        b_req_valid = 3'b000;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_flags();
        test_reset_mid();
        test_latency3();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
